// File: rtl/fir_hls_mac_pkg.sv
// Shared widths, signed range helpers and parameter legality for the FIR MAC.
package fir_hls_mac_pkg;

  // Full-precision product width of two signed operands.
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1;
  endfunction

  // Largest value representable in a signed field of width w.
  function automatic logic signed [127:0] smax(input int w);
    return (128'sd1 <<< (w - 1)) - 128'sd1;
  endfunction

  // Smallest value representable in a signed field of width w.
  function automatic logic signed [127:0] smin(input int w);
    return -(128'sd1 <<< (w - 1));
  endfunction

  // True when the accumulator can hold a product, the pipe has a stage and the shift fits.
  function automatic bit params_ok(input int acc_w, input int prod_w, input int nstage,
                                   input int shift);
    return (acc_w >= prod_w) && (nstage >= 1) && (shift >= 0) && (shift < acc_w);
  endfunction

endpackage

// File: rtl/fir_hls_round_sat.sv
// Combinational output scaling: round-half-up right shift, then clamp or wrap.
module fir_hls_round_sat
  import fir_hls_mac_pkg::*;
#(
  parameter int ACC_WIDTH  = 48,
  parameter int DOUT_WIDTH = 32,
  parameter int SHIFT      = 0,
  parameter int SATURATE   = 1
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_i,
  output logic signed [DOUT_WIDTH-1:0] dout_o,
  output logic                         ovf_o
);

  // One guard bit so the rounding constant can never overflow the accumulator range.
  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [127:0] DMAX = smax(DOUT_WIDTH);
  localparam logic signed [127:0] DMIN = smin(DOUT_WIDTH);

  logic signed [RW-1:0] acc_ext;
  logic signed [RW-1:0] r;
  logic signed [127:0]  r_ext;

  assign acc_ext = {acc_i[ACC_WIDTH-1], acc_i};

  if (SHIFT > 0) begin : g_round
    localparam logic signed [RW-1:0] RND = RW'(1) <<< (SHIFT - 1);
    assign r = (acc_ext + RND) >>> SHIFT;
  end else begin : g_pass
    assign r = acc_ext;
  end

  assign r_ext = 128'(r);

  // Range check against the output width; out-of-range results clamp or keep low bits.
  always_comb begin
    ovf_o  = 1'b0;
    dout_o = r_ext[DOUT_WIDTH-1:0];
    if (r_ext > DMAX) begin
      ovf_o = 1'b1;
      if (SATURATE != 0) dout_o = DMAX[DOUT_WIDTH-1:0];
    end else if (r_ext < DMIN) begin
      ovf_o = 1'b1;
      if (SATURATE != 0) dout_o = DMIN[DOUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fir_hls_mac_pipe.sv
// Pipelined signed MAC with valid/ready flow control and frame-delimited accumulation.
// A single global enable (output register free or being drained) advances every stage,
// so a stall freezes the whole pipe and no sample is lost or duplicated.
module fir_hls_mac_pipe
  import fir_hls_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 13,
  parameter int ACC_WIDTH  = 48,
  parameter int DOUT_WIDTH = 32,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 0,
  parameter int SATURATE   = 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         acc_first,
  input  logic                         acc_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);

  if (!params_ok(ACC_WIDTH, PW, NUM_STAGE, SHIFT)) begin : g_bad_params
    $error("fir_hls_mac_pipe: illegal ACC_WIDTH/NUM_STAGE/SHIFT combination");
  end

  logic                        en;
  logic signed [PW-1:0]        prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0]        vld_q, first_q, last_q;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, prod_ext;
  logic                        pend_q;
  logic                        out_valid_q, ovf_q;
  logic signed [DOUT_WIDTH-1:0] dout_q, rs_dout;
  logic                        rs_ovf;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

  assign prod_ext = ACC_WIDTH'(prod_q[NUM_STAGE-1]);

  // Next accumulator value: restart on first, wrap-around add otherwise, hold on bubbles.
  always_comb begin
    acc_d = acc_q;
    if (vld_q[NUM_STAGE-1]) begin
      acc_d = first_q[NUM_STAGE-1] ? prod_ext : acc_q + prod_ext;
    end
  end

  // Product register followed by plain delay stages; flags ride alongside the data.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (en) begin
      vld_q[0]   <= in_valid;
      first_q[0] <= acc_first;
      last_q[0]  <= acc_last;
      prod_q[0]  <= PW'(din0) * PW'(din1);
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_q[i]   <= vld_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
        prod_q[i]  <= prod_q[i-1];
      end
    end
  end

  // Accumulate, remember that a frame just closed, and register the scaled result one edge later.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_q       <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      acc_q       <= acc_d;
      pend_q      <= vld_q[NUM_STAGE-1] & last_q[NUM_STAGE-1];
      out_valid_q <= pend_q;
      if (pend_q) begin
        dout_q <= rs_dout;
        ovf_q  <= rs_ovf;
      end
    end
  end

  fir_hls_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .DOUT_WIDTH(DOUT_WIDTH),
    .SHIFT     (SHIFT),
    .SATURATE  (SATURATE)
  ) u_round_sat (
    .acc_i (acc_q),
    .dout_o(rs_dout),
    .ovf_o (rs_ovf)
  );

endmodule

// File: tb/tb_fir_hls_mac_pipe.sv
// Bench for fir_hls_mac_pipe: four configurations share one stimulus stream
// (default, SHIFT=4, 16-bit saturating, 16-bit wrapping) and are checked
// against a frame-level arithmetic model.
module tb_fir_hls_mac_pipe;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic in_valid = 1'b0, acc_first = 1'b0, acc_last = 1'b0, out_ready = 1'b1;
  logic signed [31:0] din0 = '0;
  logic signed [12:0] din1 = '0;

  logic in_ready0, in_ready1, in_ready2, in_ready3;
  logic out_valid0, out_valid1, out_valid2, out_valid3;
  logic ovf0, ovf1, ovf2, ovf3;
  logic signed [31:0] dout0, dout1;
  logic signed [15:0] dout2, dout3;

  fir_hls_mac_pipe u0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready0),
    .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(out_valid0), .out_ready(out_ready), .dout(dout0), .ovf(ovf0));

  fir_hls_mac_pipe #(.SHIFT(4)) u1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready1),
    .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(out_valid1), .out_ready(out_ready), .dout(dout1), .ovf(ovf1));

  fir_hls_mac_pipe #(.DOUT_WIDTH(16), .SATURATE(1)) u2 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready2),
    .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(out_valid2), .out_ready(out_ready), .dout(dout2), .ovf(ovf2));

  fir_hls_mac_pipe #(.DOUT_WIDTH(16), .SATURATE(0)) u3 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready3),
    .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(out_valid3), .out_ready(out_ready), .dout(dout3), .ovf(ovf3));

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  typedef struct {
    longint d0, d1, d2, d3;
    bit     o0, o1, o2, o3;
    int     cyc;
  } res_t;

  res_t   got[$];
  longint exp_acc[$];
  longint m_acc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  res_t   mon_r;

  // Record every output handshake that will happen at the coming rising edge.
  always begin
    @(negedge ap_clk);
    #2;
    if (!ap_rst && out_valid0 && out_ready) begin
      mon_r.d0 = longint'(dout0); mon_r.d1 = longint'(dout1);
      mon_r.d2 = longint'(dout2); mon_r.d3 = longint'(dout3);
      mon_r.o0 = ovf0; mon_r.o1 = ovf1; mon_r.o2 = ovf2; mon_r.o3 = ovf3;
      mon_r.cyc = cyc;
      got.push_back(mon_r);
    end
  end

  // Reference arithmetic -------------------------------------------------

  function automatic longint wrap48(input longint v);
    return (v <<< 16) >>> 16;
  endfunction

  function automatic void scale(input longint a, input int sh, input int dw, input bit sat,
                                output longint d, output bit o);
    longint r, mx, mn;
    if (sh > 0) r = (a + (longint'(1) <<< (sh - 1))) >>> sh;
    else        r = a;
    mx = (longint'(1) <<< (dw - 1)) - 1;
    mn = -mx - 1;
    o  = (r > mx) || (r < mn);
    if (!o)       d = r;
    else if (sat) d = (r > mx) ? mx : mn;
    else          d = (r <<< (64 - dw)) >>> (64 - dw);
  endfunction

  // Drive one sample until accepted, then update the frame model.
  task automatic send(input longint a, input longint b, input bit f, input bit l);
    bit     done = 1'b0;
    longint p;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge ap_clk);
      din0 = 32'(a); din1 = 13'(b); acc_first = f; acc_last = l; in_valid = 1'b1;
      #1;
      if (in_ready0) begin
        @(posedge ap_clk);
        #1 in_valid = 1'b0;
        done = 1'b1;
        p = a * b;
        if (f) m_acc = p;
        else   m_acc = wrap48(m_acc + p);
        if (l) exp_acc.push_back(m_acc);
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      in_valid = 1'b0;
      $display("FAIL send_timeout: sample (%0d,%0d) not accepted within 200 cycles", a, b);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (got.size() < exp_acc.size() && t < 200) begin
      @(negedge ap_clk);
      t++;
    end
    repeat (10) @(negedge ap_clk);
    #3;
    if (t >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d results, want %0d", got.size(), exp_acc.size());
    end
  endtask

  task automatic clear_q();
    got.delete();
    exp_acc.delete();
  endtask

  // Tests ----------------------------------------------------------------

  task automatic test_reset();
    ap_rst = 1'b1;
    m_acc = 0;
    repeat (3) @(negedge ap_clk);
    #2;
    n_checks++;
    if (out_valid0 !== 1'b0 || dout0 !== 32'sd0 || ovf0 !== 1'b0 || dout2 !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b dout=%0d ovf=%b dout16=%0d, want 0 0 0 0",
               out_valid0, dout0, ovf0, dout2);
    end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    #1;
    n_checks++;
    if (in_ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready0);
    end
    clear_q();
  endtask

  task automatic test_single();
    send(-3, 5, 1'b1, 1'b1);
    for (int n = 0; n <= 4; n++) begin
      @(negedge ap_clk);
      #1;
      n_checks++;
      if (out_valid0 !== (n == 4)) begin
        n_fail++;
        $display("FAIL single_latency[%0d]: out_valid=%b want %b", n, out_valid0, n == 4);
      end
    end
    n_checks++;
    if (dout0 !== -32'sd15 || ovf0 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_value: dout=%0d ovf=%b want -15 0", dout0, ovf0);
    end
    drain();
    n_checks++;
    if (got.size() != 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d results want 1", got.size());
    end
    clear_q();
  endtask

  task automatic test_back_to_back();
    longint want [2] = '{20, 7};
    send(2, 3, 1'b1, 1'b0);
    send(4, 5, 1'b0, 1'b0);
    send(-1, 6, 1'b0, 1'b1);
    send(7, 1, 1'b1, 1'b1);
    drain();
    n_checks++;
    if (got.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 2", got.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got[i].d0 !== want[i] || got[i].d0 !== exp_acc[i]) begin
          n_fail++;
          $display("FAIL b2b_value[%0d]: got %0d want %0d", i, got[i].d0, want[i]);
        end
      end
      n_checks++;
      if (got[1].cyc != got[0].cyc + 1) begin
        n_fail++;
        $display("FAIL b2b_spacing: results at cycles %0d,%0d want adjacent",
                 got[0].cyc, got[1].cyc);
      end
    end
    clear_q();
  endtask

  task automatic test_rounding();
    longint want [3] = '{2, -1, 1};
    longint raw  [3] = '{24, -24, 8};
    for (int i = 0; i < 3; i++) send(raw[i], 1, 1'b1, 1'b1);
    drain();
    n_checks++;
    if (got.size() != 3) begin
      n_fail++;
      $display("FAIL round_count: got %0d want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got[i].d1 !== want[i] || got[i].o1 !== 1'b0 || got[i].d0 !== raw[i]) begin
          n_fail++;
          $display("FAIL round[%0d]: shifted=%0d raw=%0d want %0d %0d",
                   i, got[i].d1, got[i].d0, want[i], raw[i]);
        end
      end
    end
    clear_q();
  endtask

  task automatic test_saturation();
    longint sat_w  [2] = '{32767, -32768};
    longint wrap_w [2] = '{31072, -31072};
    longint full_w [2] = '{409500000, -409500000};
    send(100000, 4095, 1'b1, 1'b1);
    send(-100000, 4095, 1'b1, 1'b1);
    drain();
    n_checks++;
    if (got.size() != 2) begin
      n_fail++;
      $display("FAIL sat_count: got %0d want 2", got.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got[i].d2 !== sat_w[i] || got[i].o2 !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_clamp[%0d]: got %0d ovf=%b want %0d ovf=1",
                   i, got[i].d2, got[i].o2, sat_w[i]);
        end
        n_checks++;
        if (got[i].d3 !== wrap_w[i] || got[i].o3 !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_wrap[%0d]: got %0d ovf=%b want %0d ovf=1",
                   i, got[i].d3, got[i].o3, wrap_w[i]);
        end
        n_checks++;
        if (got[i].d0 !== full_w[i] || got[i].o0 !== 1'b0) begin
          n_fail++;
          $display("FAIL sat_wide[%0d]: got %0d ovf=%b want %0d ovf=0",
                   i, got[i].d0, got[i].o0, full_w[i]);
        end
      end
    end
    clear_q();
  endtask

  task automatic test_backpressure();
    logic signed [31:0] held = '0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(i + 1, 7, 1'b1, 1'b1);
      end
      begin
        repeat (5) @(negedge ap_clk);
        for (int s = 0; s < 5; s++) begin
          @(negedge ap_clk);
          out_ready = 1'b0;
          #2;
          if (s == 0) held = dout0;
          n_checks++;
          if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || dout0 !== held) begin
            n_fail++;
            $display("FAIL bp_stall[%0d]: out_valid=%b in_ready=%b dout=%0d want 1 0 %0d",
                     s, out_valid0, in_ready0, dout0, held);
          end
        end
        @(negedge ap_clk);
        out_ready = 1'b1;
      end
    join
    drain();
    n_checks++;
    if (got.size() != 10) begin
      n_fail++;
      $display("FAIL bp_count: got %0d want 10", got.size());
    end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      n_checks++;
      if (got[i].d0 !== longint'((i + 1) * 7)) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: got %0d want %0d", i, got[i].d0, (i + 1) * 7);
      end
    end
    clear_q();
  endtask

  task automatic test_reset_midframe();
    send(5, 5, 1'b1, 1'b0);
    send(6, 6, 1'b0, 1'b0);
    @(negedge ap_clk);
    ap_rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge ap_clk);
      #2;
      n_checks++;
      if (out_valid0 !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_valid[%0d]: out_valid=%b want 0", k, out_valid0);
      end
    end
    ap_rst = 1'b0;
    m_acc = 0;
    clear_q();
    send(1, 1, 1'b1, 1'b0);
    send(1, 1, 1'b0, 1'b1);
    drain();
    n_checks++;
    if (got.size() != 1) begin
      n_fail++;
      $display("FAIL rst_mid_count: got %0d results want 1", got.size());
    end else begin
      n_checks++;
      if (got[0].d0 !== 64'sd2) begin
        n_fail++;
        $display("FAIL rst_mid_value: got %0d want 2", got[0].d0);
      end
    end
    clear_q();
  endtask

  task automatic test_random();
    bit     rdone = 1'b0;
    longint ed;
    bit     eo;
    fork
      begin
        for (int fr = 0; fr < 40; fr++) begin
          int len = int'($urandom_range(1, 4));
          for (int j = 0; j < len; j++) begin
            longint a = longint'($signed($urandom));
            longint b = longint'(int'($urandom_range(0, 8191)) - 4096);
            bit     f = (j == 0) && ($urandom_range(0, 7) != 0);
            send(a, b, f, j == len - 1);
            if ($urandom_range(0, 5) == 0) @(negedge ap_clk);
          end
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(negedge ap_clk);
          out_ready = ($urandom_range(0, 3) != 0);
          #2;
          n_checks++;
          if (in_ready0 !== (!out_valid0 || out_ready) ||
              in_ready1 !== in_ready0 || in_ready2 !== in_ready0 || in_ready3 !== in_ready0 ||
              out_valid1 !== out_valid0 || out_valid2 !== out_valid0 ||
              out_valid3 !== out_valid0) begin
            n_fail++;
            $display("FAIL rand_flow: in_ready=%b%b%b%b out_valid=%b%b%b%b out_ready=%b",
                     in_ready0, in_ready1, in_ready2, in_ready3,
                     out_valid0, out_valid1, out_valid2, out_valid3, out_ready);
          end
        end
        out_ready = 1'b1;
      end
    join
    drain();
    n_checks++;
    if (got.size() != exp_acc.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d want %0d", got.size(), exp_acc.size());
    end
    for (int i = 0; i < got.size() && i < exp_acc.size(); i++) begin
      scale(exp_acc[i], 0, 32, 1'b1, ed, eo);
      n_checks++;
      if (got[i].d0 !== ed || got[i].o0 !== eo) begin
        n_fail++;
        $display("FAIL rand_def[%0d]: got %0d/%b want %0d/%b", i, got[i].d0, got[i].o0, ed, eo);
      end
      scale(exp_acc[i], 4, 32, 1'b1, ed, eo);
      n_checks++;
      if (got[i].d1 !== ed || got[i].o1 !== eo) begin
        n_fail++;
        $display("FAIL rand_shift[%0d]: got %0d/%b want %0d/%b", i, got[i].d1, got[i].o1, ed, eo);
      end
      scale(exp_acc[i], 0, 16, 1'b1, ed, eo);
      n_checks++;
      if (got[i].d2 !== ed || got[i].o2 !== eo) begin
        n_fail++;
        $display("FAIL rand_sat[%0d]: got %0d/%b want %0d/%b", i, got[i].d2, got[i].o2, ed, eo);
      end
      scale(exp_acc[i], 0, 16, 1'b0, ed, eo);
      n_checks++;
      if (got[i].d3 !== ed || got[i].o3 !== eo) begin
        n_fail++;
        $display("FAIL rand_wrap[%0d]: got %0d/%b want %0d/%b", i, got[i].d3, got[i].o3, ed, eo);
      end
    end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
